// File: rtl/weight_load_ctrl.sv
// Weight image load sequencer: streams conv1/conv2/fc weights from a valid/ready
// source into buffer_Weight, issues the closing ce that makes the buffer raise
// o_full, and reports per-segment and overall completion.
module weight_load_ctrl #(
  parameter int unsigned BW    = 8,
  parameter int unsigned SIZE1 = 150,
  parameter int unsigned SIZE2 = 2400,
  parameter int unsigned SIZE3 = 670,
  parameter int unsigned TMO   = 64
) (
  input  logic          clk,
  input  logic          global_rst_n,
  input  logic          i_start,
  input  logic [BW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_buf_ce,
  output logic [BW-1:0] o_buf_data,
  input  logic          i_buf_full,
  output logic [2:0]    o_seg_done,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int unsigned Total = SIZE1 + SIZE2 + SIZE3;
  localparam int unsigned CntW  = $clog2(Total + 1);
  localparam int unsigned TmoW  = $clog2(TMO + 1);

  // Word indices whose buffer write completes a segment
  localparam logic [CntW-1:0] LastSeg1 = CntW'(SIZE1 - 1);
  localparam logic [CntW-1:0] LastSeg2 = CntW'(SIZE1 + SIZE2 - 1);
  localparam logic [CntW-1:0] LastWord = CntW'(Total - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TMO - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StConfirm,
    StDone,
    StErr
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            extra_q, extra_d;
  logic            ce_q, ce_d;
  logic [BW-1:0]   data_q, data_d;
  logic [2:0]      seg_q, seg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Ready depends only on state so the source sees a stable value all cycle
  assign o_ready    = (state_q == StLoad);
  assign o_buf_ce   = ce_q;
  assign o_buf_data = data_q;
  assign o_seg_done = seg_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    extra_d = extra_q;
    ce_d    = 1'b0;
    data_d  = data_q;
    seg_d   = seg_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end

      StLoad: begin
        if (i_buf_full) begin
          // Buffer filled early: size mismatch, stop writing immediately
          state_d = StErr;
          err_d   = 1'b1;
        end else if (i_valid) begin
          ce_d   = 1'b1;
          data_d = i_data;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastSeg1) seg_d[0] = 1'b1;
          if (cnt_q == LastSeg2) seg_d[1] = 1'b1;
          if (cnt_q == LastWord) begin
            seg_d[2] = 1'b1;
            state_d  = StConfirm;
            extra_d  = 1'b0;
            tmo_d    = '0;
          end
        end
      end

      StConfirm: begin
        if (i_buf_full) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (!extra_q) begin
          // buffer_Weight only raises o_full on a ce once its count reached SIZE
          ce_d    = 1'b1;
          extra_d = 1'b1;
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      // Terminal: only global reset recovers, since the buffer cannot be cleared
      StDone, StErr: begin
        state_d = state_q;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StLoad) || (state_d == StConfirm);
  end

  // State and output registers
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tmo_q   <= '0;
      extra_q <= 1'b0;
      ce_q    <= 1'b0;
      data_q  <= '0;
      seg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      extra_q <= extra_d;
      ce_q    <= ce_d;
      data_q  <= data_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: a reference buffer model plus a scoreboard of
// expected buffer writes derived from the word index of each accepted word.
module tb_weight_load_ctrl;

  localparam int S1    = 150;
  localparam int S2    = 2400;
  localparam int S3    = 670;
  localparam int TOTAL = S1 + S2 + S3;
  localparam int TMO   = 64;

  logic       clk, rst_n, i_start, i_valid, i_buf_full;
  logic [7:0] i_data, o_buf_data;
  logic       o_ready, o_buf_ce, o_busy, o_done, o_err;
  logic [2:0] o_seg_done;

  int checks = 0;
  int failures = 0;
  int ce_cnt = 0;
  int cyc = 0;
  int last_ce_cyc = 0;

  logic        force_full = 1'b0;
  logic        hold_empty = 1'b0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;

  // Reference buffer_Weight behaviour
  logic [7:0] b_mem[TOTAL];
  int         b_cnt;
  logic       b_full;

  weight_load_ctrl #(
    .BW(8), .SIZE1(S1), .SIZE2(S2), .SIZE3(S3), .TMO(TMO)
  ) dut (
    .clk         (clk),
    .global_rst_n(rst_n),
    .i_start     (i_start),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_buf_ce    (o_buf_ce),
    .o_buf_data  (o_buf_data),
    .i_buf_full  (i_buf_full),
    .o_seg_done  (o_seg_done),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt  <= 0;
      b_full <= 1'b0;
    end else if (o_buf_ce) begin
      if (b_cnt < TOTAL) begin
        b_mem[b_cnt] <= o_buf_data;
        b_cnt        <= b_cnt + 1;
      end else begin
        b_full <= 1'b1;
      end
    end
  end

  assign i_buf_full = force_full ? 1'b1 : (hold_empty ? 1'b0 : b_full);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] seg_for(input int idx);
    return {idx >= TOTAL - 1, idx >= S1 + S2 - 1, idx >= S1 - 1};
  endfunction

  // Monitor: every buffer write must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n && o_buf_ce) begin
      ce_cnt++;
      last_ce_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_ce", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ce_data", int'(o_buf_data), int'(mon_e[10:3]));
        chk("seg_done", int'(o_seg_done), int'(mon_e[2:0]));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Drives words 0,1,2.. until TOTAL accepted or cut_at accepted
  task automatic run_load(input int gap_pct, input int cut_at, input bit rand_start);
    int         idx = 0;
    int         n = 0;
    logic [7:0] d;
    while (idx < TOTAL && idx != cut_at) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        chk("load_timeout", idx, TOTAL);
        break;
      end
      i_valid = ($urandom_range(0, 99) >= gap_pct);
      i_start = rand_start && ($urandom_range(0, 15) == 0);
      d       = 8'(idx);
      i_data  = i_valid ? d : 8'($urandom);
      if (i_valid && o_ready) begin
        exp_q.push_back({d, seg_for(idx)});
        idx++;
        if (idx == TOTAL) exp_q.push_back({d, 3'b111});
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_start = 1'b0;
    if (idx == TOTAL) chk("ready_drop_after_last", int'(o_ready), 0);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(o_done || o_err) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("end_timeout", n, 0);
  endtask

  task automatic check_full_load(input string tag);
    int bad = 0;
    wait_end();
    chk({tag, "_done"}, int'(o_done), 1);
    chk({tag, "_err"}, int'(o_err), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_seg"}, int'(o_seg_done), 7);
    chk({tag, "_ce_count"}, ce_cnt, TOTAL + 1);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_buf_full"}, int'(b_full), 1);
    for (int k = 0; k < TOTAL; k++) if (b_mem[k] != 8'(k)) bad++;
    chk({tag, "_buf_contents_bad"}, bad, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_start    = 1'b0;
    force_full = 1'b0;
    hold_empty = 1'b0;
    #1;
    chk("reset_outputs", int'({o_ready, o_buf_ce, o_buf_data, o_seg_done, o_busy, o_done, o_err}),
        0);
    chk("reset_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    ce_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ce0;
    int t0;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (3) @(negedge clk);
    chk("por_outputs", int'({o_ready, o_buf_ce, o_buf_data, o_seg_done, o_busy, o_done, o_err}), 0);
    rst_n = 1'b1;

    // Continuous stream
    pulse_start();
    chk("busy_in_load", int'(o_busy), 1);
    chk("ready_in_load", int'(o_ready), 1);
    run_load(0, -1, 1'b0);
    check_full_load("cont");
    apply_reset();

    // Bubbles plus stray start pulses while busy
    pulse_start();
    run_load(30, -1, 1'b1);
    check_full_load("gaps");
    apply_reset();

    // Buffer never reports full: timeout after the closing ce
    hold_empty = 1'b1;
    pulse_start();
    run_load(0, -1, 1'b0);
    t0 = 0;
    while (!o_err && t0 < 300) begin
      @(negedge clk);
      t0++;
    end
    chk("tmo_err", int'(o_err), 1);
    chk("tmo_cycles", cyc - last_ce_cyc, TMO);
    chk("tmo_done_low", int'(o_done), 0);
    chk("tmo_ce_count", ce_cnt, TOTAL + 1);
    apply_reset();

    // Premature full at word 1000
    pulse_start();
    run_load(0, 1000, 1'b0);
    force_full = 1'b1;
    @(negedge clk);
    chk("early_full_err", int'(o_err), 1);
    chk("early_full_ready", int'(o_ready), 0);
    chk("early_full_busy", int'(o_busy), 0);
    ce0 = ce_cnt;
    chk("early_full_ce_count", ce0, 1000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = 8'($urandom);
    end
    i_valid = 1'b0;
    chk("early_full_no_more_ce", ce_cnt, ce0);
    chk("early_full_err_sticky", int'(o_err), 1);
    apply_reset();

    // Reset mid-load, then a clean reload
    pulse_start();
    run_load(10, 500, 1'b0);
    apply_reset();
    pulse_start();
    run_load(0, -1, 1'b0);
    check_full_load("reload");
    ce0 = ce_cnt;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("done_start_no_ce", ce_cnt, ce0);
    chk("done_sticky", int'(o_done), 1);
    chk("done_ready_low", int'(o_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
